alu_op_scheduler: RTL

ALU_OP_SCHEDULER -- requirements
Module: alu_op_scheduler

---
 rtl/alu_op_scheduler.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/alu_op_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : alu_op_scheduler
//  Description : Queues ALU commands in a small FIFO, issues them one at a
//                time to an external fixed-latency ALU, masks the returned
//                result by operation and presents it on a ready/valid
//                response port, strictly in command order.
//
//  Ports
//    clk, rst_n                 clock (rising edge), synchronous active-low reset
//    cmd_valid/cmd_ready        command handshake (ready = FIFO not full)
//    cmd_op, cmd_a, cmd_b       operation (0 ADD, 1 MUL, 2 OR, 3 AND), operands
//    alu_start                  one-cycle start pulse to the ALU
//    alu_op, alu_a, alu_b       held to the ALU from ISSUE through last WAIT
//    alu_result                 ALU result, sampled at the end of the last WAIT
//    rsp_valid/rsp_ready        response handshake
//    rsp_op, rsp_result         completed operation and masked result
//    busy                       FSM not idle or FIFO non-empty
//    chk_err                    sticky self-check error flag
//
//  Parameters
//    FIFO_DEPTH  command FIFO entries (power of 2, >= 2)
//    ALU_LATENCY cycles from the alu_start cycle until alu_result is valid
//
//  Build option
//    ALU_OP_SCHEDULER_CHECK_EN  when defined, recomputes the expected result
//                               from the held operands and flags mismatches
//                               on chk_err; otherwise chk_err is tied low.
//
//  Revision    : 1.0  initial release
// ============================================================================

package typedef_pkg;
   typedef enum logic [1:0] {
      OP_ADD = 2'd0,
      OP_MUL = 2'd1,
      OP_OR  = 2'd2,
      OP_AND = 2'd3
   } operation_t;
endpackage

module alu_op_scheduler #(
   parameter int FIFO_DEPTH  = 4,
   parameter int ALU_LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_op,
   input  logic [7:0]  cmd_a,
   input  logic [7:0]  cmd_b,
   output logic        alu_start,
   output logic [1:0]  alu_op,
   output logic [7:0]  alu_a,
   output logic [7:0]  alu_b,
   input  logic [15:0] alu_result,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [1:0]  rsp_op,
   output logic [15:0] rsp_result,
   output logic        busy,
   output logic        chk_err
);
   import typedef_pkg::*;

   localparam int c_ptr_w  = $clog2(FIFO_DEPTH);
   localparam int c_wait_w = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;
   localparam logic [c_wait_w-1:0] c_wait_init = c_wait_w'(ALU_LATENCY - 1);
   localparam logic [c_wait_w-1:0] c_wait_one  = c_wait_w'(1);
   localparam logic [c_ptr_w-1:0]  c_ptr_one   = c_ptr_w'(1);
   localparam logic [c_ptr_w:0]    c_cnt_one   = (c_ptr_w+1)'(1);
   localparam logic [c_ptr_w:0]    c_cnt_full  = (c_ptr_w+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t              r_state;
   logic [17:0]         r_mem [FIFO_DEPTH];
   logic [c_ptr_w-1:0]  r_wr_ptr;
   logic [c_ptr_w-1:0]  r_rd_ptr;
   logic [c_ptr_w:0]    r_count;
   logic [c_wait_w-1:0] r_wait_cnt;

   logic        w_full;
   logic        w_empty;
   logic        w_push;
   logic        w_pop;
   logic        w_capture;
   logic [17:0] w_head;

   // Keep only the bits that are meaningful for each operation.
   function automatic logic [15:0] mask_result(input logic [1:0] op, input logic [15:0] raw);
      logic [15:0] m;
      case (operation_t'(op))
         OP_ADD:  m = {7'd0, raw[8:0]};
         OP_MUL:  m = raw;
         default: m = {8'd0, raw[7:0]};
      endcase
      return m;
   endfunction

   assign w_full    = (r_count == c_cnt_full);
   assign w_empty   = (r_count == '0);
   assign w_push    = cmd_valid && !w_full;
   // The head leaves the FIFO on the edge that enters ISSUE.
   assign w_pop     = !w_empty && ((r_state == S_IDLE) || ((r_state == S_RESP) && rsp_ready));
   assign w_capture = (r_state == S_WAIT) && (r_wait_cnt == '0);
   assign w_head    = r_mem[r_rd_ptr];

   assign cmd_ready = !w_full;
   assign busy      = (r_state != S_IDLE) || !w_empty;

   // ------------------------------------------------------------------ FIFO
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= {cmd_op, cmd_a, cmd_b};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         // Depth is a power of two, so pointers wrap by natural overflow.
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + c_ptr_one;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_ptr_one;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + c_cnt_one;
            2'b01:   r_count <= r_count - c_cnt_one;
            default: r_count <= r_count;
         endcase
      end
   end

   // ------------------------------------------------------------------- FSM
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_wait_cnt <= '0;
         alu_start  <= 1'b0;
         alu_op     <= '0;
         alu_a      <= '0;
         alu_b      <= '0;
         rsp_valid  <= 1'b0;
         rsp_op     <= '0;
         rsp_result <= '0;
      end else begin
         alu_start <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_pop) begin
                  r_state                 <= S_ISSUE;
                  alu_start               <= 1'b1;
                  {alu_op, alu_a, alu_b}  <= w_head;
               end
            end
            S_ISSUE: begin
               r_state    <= S_WAIT;
               r_wait_cnt <= c_wait_init;
            end
            S_WAIT: begin
               if (w_capture) begin
                  r_state    <= S_RESP;
                  rsp_valid  <= 1'b1;
                  rsp_op     <= alu_op;
                  rsp_result <= mask_result(alu_op, alu_result);
               end else begin
                  r_wait_cnt <= r_wait_cnt - c_wait_one;
               end
            end
            S_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  if (w_pop) begin
                     r_state                <= S_ISSUE;
                     alu_start              <= 1'b1;
                     {alu_op, alu_a, alu_b} <= w_head;
                  end else begin
                     r_state <= S_IDLE;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // ------------------------------------------------------------ self-check
`ifdef ALU_OP_SCHEDULER_CHECK_EN
   logic [15:0] w_expected;
   logic        r_chk_err;

   always_comb begin
      w_expected = '0;
      case (operation_t'(alu_op))
         OP_ADD:  w_expected = {8'd0, alu_a} + {8'd0, alu_b};
         OP_MUL:  w_expected = {8'd0, alu_a} * {8'd0, alu_b};
         OP_OR:   w_expected = {8'd0, alu_a | alu_b};
         default: w_expected = {8'd0, alu_a & alu_b};
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_chk_err <= 1'b0;
      end else if (w_capture &&
                   (mask_result(alu_op, alu_result) != mask_result(alu_op, w_expected))) begin
         r_chk_err <= 1'b1;
      end
   end

   assign chk_err = r_chk_err;
`else
   assign chk_err = 1'b0;
`endif

endmodule
`default_nettype wire
